// File: rtl/interrupt_controller_pkg.sv
// Shared constants for the interrupt controller: SPR numbers, exception codes,
// MSR/ESR bit positions (IBM numbering, bit 0 = MSB) and the source table.
package interrupt_controller_pkg;

    localparam int unsigned EXC_W    = 4;
    localparam int unsigned NUM_IVOR = 16;
    localparam int unsigned NUM_SRC  = 8;

    localparam logic [9:0] SPRN_SRR1  = 10'd27;
    localparam logic [9:0] SPRN_ESR   = 10'd62;
    localparam logic [9:0] SPRN_IVPR  = 10'd63;
    localparam logic [9:0] SPRN_IVOR0 = 10'd400;

    localparam logic [3:0] EXC_NONE = 4'd0;
    localparam logic [3:0] EXC_DSI  = 4'd1;
    localparam logic [3:0] EXC_ISI  = 4'd2;
    localparam logic [3:0] EXC_DEV0 = 4'd3;
    localparam logic [3:0] EXC_DEV1 = 4'd4;
    localparam logic [3:0] EXC_PROG = 4'd5;
    localparam logic [3:0] EXC_SC   = 4'd6;
    localparam logic [3:0] EXC_DTLB = 4'd7;
    localparam logic [3:0] EXC_ITLB = 4'd8;

    localparam int unsigned MSR_EE = 16;
    localparam int unsigned MSR_PR = 17;

    localparam int unsigned ESR_PE_MSB = 4;
    localparam int unsigned ESR_PE_LSB = 6;

    // Encoding order is the arbitration order: lower value wins.
    typedef enum logic [2:0] {
        SRC_PROG, SRC_SC, SRC_ISI, SRC_ITLB, SRC_DSI, SRC_DTLB, SRC_DEV0, SRC_DEV1
    } src_e;

    typedef enum logic {ST_IDLE, ST_WAIT} grant_state_e;

    function automatic logic [3:0] src_code(input src_e s);
        case (s)
            SRC_PROG: return EXC_PROG;
            SRC_SC:   return EXC_SC;
            SRC_ISI:  return EXC_ISI;
            SRC_ITLB: return EXC_ITLB;
            SRC_DSI:  return EXC_DSI;
            SRC_DTLB: return EXC_DTLB;
            SRC_DEV0: return EXC_DEV0;
            default:  return EXC_DEV1;
        endcase
    endfunction

    function automatic logic [3:0] src_ivor(input src_e s);
        case (s)
            SRC_PROG: return 4'd6;
            SRC_SC:   return 4'd8;
            SRC_ISI:  return 4'd3;
            SRC_ITLB: return 4'd14;
            SRC_DSI:  return 4'd2;
            SRC_DTLB: return 4'd13;
            SRC_DEV0: return 4'd4;
            default:  return 4'd5;
        endcase
    endfunction

endpackage

// File: rtl/interrupt_controller_spr_file.sv
// Interrupt SPR file: three software R/W ports, a hardware SRR1/ESR update port
// and the vector address formed from IVPR and a selected IVOR.
module interrupt_controller_spr_file
    import interrupt_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  i_addr [3],
    input  logic [0:31] i_wd   [3],
    input  logic [2:0]  i_wr,
    output logic [0:31] o_rd   [3],
    input  logic        i_hw_srr1_we,
    input  logic [0:31] i_hw_srr1_d,
    input  logic        i_hw_esr_we,
    input  logic [2:0]  i_hw_esr_pe,
    input  logic [3:0]  i_vec_sel,
    output logic [0:31] o_vec
);

    logic [0:31] r_esr;
    logic [0:31] r_ivpr;
    logic [0:31] r_srr1;
    logic [0:31] r_ivor [NUM_IVOR];

    logic [0:31] w_esr_nxt;
    logic [0:31] w_ivpr_nxt;
    logic [0:31] w_srr1_nxt;
    logic [0:31] w_ivor_nxt [NUM_IVOR];

    // Later ports overwrite earlier ones; the hardware update is applied last.
    always_comb begin
        w_esr_nxt  = r_esr;
        w_ivpr_nxt = r_ivpr;
        w_srr1_nxt = r_srr1;
        w_ivor_nxt = r_ivor;
        for (int unsigned p = 0; p < 3; p++) begin
            if (i_wr[p]) begin
                if (i_addr[p] == SPRN_ESR)  w_esr_nxt  = i_wd[p];
                if (i_addr[p] == SPRN_IVPR) w_ivpr_nxt = i_wd[p];
                if (i_addr[p] == SPRN_SRR1) w_srr1_nxt = i_wd[p];
                for (int unsigned i = 0; i < NUM_IVOR; i++) begin
                    if (i_addr[p] == SPRN_IVOR0 + 10'(i)) w_ivor_nxt[i] = i_wd[p];
                end
            end
        end
        if (i_hw_srr1_we) w_srr1_nxt = i_hw_srr1_d;
        if (i_hw_esr_we) begin
            w_esr_nxt = r_esr;
            w_esr_nxt[ESR_PE_MSB:ESR_PE_LSB] = i_hw_esr_pe;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_esr  <= '0;
            r_ivpr <= '0;
            r_srr1 <= '0;
            for (int unsigned i = 0; i < NUM_IVOR; i++) r_ivor[i] <= '0;
        end else begin
            r_esr  <= w_esr_nxt;
            r_ivpr <= w_ivpr_nxt;
            r_srr1 <= w_srr1_nxt;
            for (int unsigned i = 0; i < NUM_IVOR; i++) r_ivor[i] <= w_ivor_nxt[i];
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < 3; p++) begin
            o_rd[p] = '0;
            if (i_addr[p] == SPRN_ESR)  o_rd[p] = r_esr;
            if (i_addr[p] == SPRN_IVPR) o_rd[p] = r_ivpr;
            if (i_addr[p] == SPRN_SRR1) o_rd[p] = r_srr1;
            for (int unsigned i = 0; i < NUM_IVOR; i++) begin
                if (i_addr[p] == SPRN_IVOR0 + 10'(i)) o_rd[p] = r_ivor[i];
            end
        end
    end

    assign o_vec = {r_ivpr[0:15], r_ivor[i_vec_sel][16:27], 4'b0000};

endmodule

// File: rtl/interrupt_controller.sv
// Exception/interrupt unit: fixed-priority arbiter over eight level requests,
// a two-state grant FSM and the interrupt SPR file.
module interrupt_controller #(
    parameter int unsigned EXC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       addr0,
    input  logic [9:0]       addr1,
    input  logic [9:0]       addr2,
    input  logic [0:31]      wd0,
    input  logic [0:31]      wd1,
    input  logic [0:31]      wd2,
    input  logic             wr0,
    input  logic             wr1,
    input  logic             wr2,
    output logic [0:31]      rd0,
    output logic [0:31]      rd1,
    output logic [0:31]      rd2,
    input  logic [0:31]      MSR,
    input  logic             DSI_req,
    input  logic             ISI_req,
    input  logic             ITLB_req,
    input  logic             DTLB_req,
    input  logic             DEV0_req,
    input  logic             DEV1_req,
    input  logic             progErr_req,
    input  logic             SC_req,
    input  logic [2:0]       progErrCode,
    output logic             DSI_ack,
    output logic             ISI_ack,
    output logic             ITLB_ack,
    output logic             DTLB_ack,
    output logic             DEV0_ack,
    output logic             DEV1_ack,
    output logic             progErr_ack,
    output logic             SC_ack,
    output logic             ack,
    output logic [EXC_W-1:0] excepCode,
    output logic [0:31]      intrEntryAddr
);

    import interrupt_controller_pkg::*;

    logic [9:0]         w_addr [3];
    logic [0:31]        w_wd   [3];
    logic [0:31]        w_rd   [3];
    logic [NUM_SRC-1:0] w_req;
    logic               w_any;
    logic               w_found;
    src_e               w_win;
    logic               w_grant;
    logic [0:31]        w_vec;

    grant_state_e       r_state;
    logic [NUM_SRC-1:0] r_acks;
    logic               r_ack;
    logic [EXC_W-1:0]   r_code;
    logic [0:31]        r_vec;

    assign w_addr[0] = addr0;
    assign w_addr[1] = addr1;
    assign w_addr[2] = addr2;
    assign w_wd[0]   = wd0;
    assign w_wd[1]   = wd1;
    assign w_wd[2]   = wd2;
    assign rd0       = w_rd[0];
    assign rd1       = w_rd[1];
    assign rd2       = w_rd[2];

    assign w_req[SRC_PROG] = progErr_req;
    assign w_req[SRC_SC]   = SC_req;
    assign w_req[SRC_ISI]  = ISI_req;
    assign w_req[SRC_ITLB] = ITLB_req;
    assign w_req[SRC_DSI]  = DSI_req;
    assign w_req[SRC_DTLB] = DTLB_req;
    assign w_req[SRC_DEV0] = DEV0_req & MSR[MSR_EE];
    assign w_req[SRC_DEV1] = DEV1_req & MSR[MSR_EE];

    assign w_any = |w_req;

    always_comb begin
        w_win   = SRC_DEV1;
        w_found = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (!w_found && w_req[k]) begin
                w_win   = src_e'(3'(k));
                w_found = 1'b1;
            end
        end
    end

    assign w_grant = (r_state == ST_IDLE) && w_any;

    interrupt_controller_spr_file u_spr_file (
        .clk          (clk),
        .rst          (rst),
        .i_addr       (w_addr),
        .i_wd         (w_wd),
        .i_wr         ({wr2, wr1, wr0}),
        .o_rd         (w_rd),
        .i_hw_srr1_we (w_grant),
        .i_hw_srr1_d  (MSR),
        .i_hw_esr_we  (w_grant && (w_win == SRC_PROG)),
        .i_hw_esr_pe  (progErrCode),
        .i_vec_sel    (src_ivor(w_win)),
        .o_vec        (w_vec)
    );

    // WAIT gives the acked source one cycle to drop its level request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_acks  <= '0;
            r_ack   <= 1'b0;
            r_code  <= EXC_W'(EXC_NONE);
            r_vec   <= '0;
        end else begin
            r_acks <= '0;
            r_ack  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_acks[w_win] <= 1'b1;
                        r_ack         <= 1'b1;
                        r_code        <= EXC_W'(src_code(w_win));
                        r_vec         <= w_vec;
                        r_state       <= ST_WAIT;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign progErr_ack   = r_acks[SRC_PROG];
    assign SC_ack        = r_acks[SRC_SC];
    assign ISI_ack       = r_acks[SRC_ISI];
    assign ITLB_ack      = r_acks[SRC_ITLB];
    assign DSI_ack       = r_acks[SRC_DSI];
    assign DTLB_ack      = r_acks[SRC_DTLB];
    assign DEV0_ack      = r_acks[SRC_DEV0];
    assign DEV1_ack      = r_acks[SRC_DEV1];
    assign ack           = r_ack;
    assign excepCode     = r_code;
    assign intrEntryAddr = r_vec;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller against a table-driven model.
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  addr0, addr1, addr2;
    logic [31:0] wd0, wd1, wd2;
    logic        wr0, wr1, wr2;
    logic [31:0] rd0, rd1, rd2;
    logic [31:0] MSR;
    logic [7:0]  breq;
    logic [2:0]  progErrCode;
    logic        DSI_ack, ISI_ack, ITLB_ack, DTLB_ack, DEV0_ack, DEV1_ack, progErr_ack, SC_ack;
    logic        ack;
    logic [3:0]  excepCode;
    logic [31:0] intrEntryAddr;
    logic [7:0]  back;

    // Source numbering here: 0 DSI, 1 ISI, 2 ITLB, 3 DTLB, 4 DEV0, 5 DEV1, 6 PROG, 7 SC
    localparam int S_DSI = 0, S_ITLB = 2, S_DTLB = 3, S_DEV0 = 4, S_DEV1 = 5, S_PROG = 6, S_SC = 7;
    int code_t [8] = '{1, 2, 8, 7, 3, 4, 5, 6};
    int ivor_t [8] = '{2, 3, 14, 13, 4, 5, 6, 8};
    int prio_t [8] = '{6, 7, 1, 2, 0, 3, 4, 5};

    logic [31:0] m_spr [1024];
    int n_pass = 0;
    int n_total = 0;

    assign back = {SC_ack, progErr_ack, DEV1_ack, DEV0_ack, DTLB_ack, ITLB_ack, ISI_ack, DSI_ack};

    interrupt_controller #(.EXC_W(4)) dut (
        .clk(clk), .rst(rst),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wd0(wd0), .wd1(wd1), .wd2(wd2),
        .wr0(wr0), .wr1(wr1), .wr2(wr2),
        .rd0(rd0), .rd1(rd1), .rd2(rd2),
        .MSR(MSR),
        .DSI_req(breq[0]), .ISI_req(breq[1]), .ITLB_req(breq[2]), .DTLB_req(breq[3]),
        .DEV0_req(breq[4]), .DEV1_req(breq[5]), .progErr_req(breq[6]), .SC_req(breq[7]),
        .progErrCode(progErrCode),
        .DSI_ack(DSI_ack), .ISI_ack(ISI_ack), .ITLB_ack(ITLB_ack), .DTLB_ack(DTLB_ack),
        .DEV0_ack(DEV0_ack), .DEV1_ack(DEV1_ack), .progErr_ack(progErr_ack), .SC_ack(SC_ack),
        .ack(ack), .excepCode(excepCode), .intrEntryAddr(intrEntryAddr)
    );

    always #5 clk = ~clk;

    function automatic bit mapped(input int a);
        return (a == 27) || (a == 62) || (a == 63) || (a >= 400 && a <= 415);
    endfunction

    function automatic logic [31:0] m_read(input int a);
        return mapped(a) ? m_spr[a] : 32'h0;
    endfunction

    function automatic int exp_winner(input logic [7:0] req, input logic ee);
        for (int k = 0; k < 8; k++) begin
            if (req[prio_t[k]] && (ee || (prio_t[k] != S_DEV0 && prio_t[k] != S_DEV1)))
                return prio_t[k];
        end
        return -1;
    endfunction

    function automatic logic [31:0] exp_vec(input int s);
        logic [31:0] ivpr, ivor;
        ivpr = m_spr[63];
        ivor = m_spr[400 + ivor_t[s]];
        return {ivpr[31:16], ivor[15:4], 4'h0};
    endfunction

    task automatic clear_model();
        for (int a = 0; a < 1024; a++) m_spr[a] = 32'h0;
    endtask

    task automatic write3(input int a0, input logic [31:0] d0, input int a1, input logic [31:0] d1,
                          input int a2, input logic [31:0] d2);
        @(negedge clk);
        addr0 = 10'(a0); wd0 = d0; wr0 = 1'b1;
        addr1 = 10'(a1); wd1 = d1; wr1 = 1'b1;
        addr2 = 10'(a2); wd2 = d2; wr2 = 1'b1;
        @(posedge clk); #1;
        wr0 = 1'b0; wr1 = 1'b0; wr2 = 1'b0;
        if (mapped(a0)) m_spr[a0] = d0;
        if (mapped(a1)) m_spr[a1] = d1;
        if (mapped(a2)) m_spr[a2] = d2;
    endtask

    task automatic expect_grant(input int s);
        logic seen;
        logic [31:0] ev;
        logic [7:0] oh;
        ev = exp_vec(s);
        oh = '0; oh[s] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            if (ack === 1'b1) seen = 1'b1;
        end
        n_total++;
        if (!seen) $display("FAIL grant_timeout src=%0d: ack=0 required 1", s);
        else n_pass++;
        if (seen) begin
            m_spr[27] = MSR;
            if (s == S_PROG) m_spr[62][27:25] = progErrCode;
            n_total++;
            if (back !== oh) $display("FAIL src_ack src=%0d: got %b required %b", s, back, oh);
            else n_pass++;
            n_total++;
            if (excepCode !== 4'(code_t[s])) $display("FAIL excepCode src=%0d: got %0d required %0d", s, excepCode, code_t[s]);
            else n_pass++;
            n_total++;
            if (intrEntryAddr !== ev) $display("FAIL intrEntryAddr src=%0d: got %h required %h", s, intrEntryAddr, ev);
            else n_pass++;
            addr1 = 10'd27; addr2 = 10'd62; #1;
            n_total++;
            if (rd1 !== m_spr[27]) $display("FAIL srr1 src=%0d: got %h required %h", s, rd1, m_spr[27]);
            else n_pass++;
            n_total++;
            if (rd2 !== m_spr[62]) $display("FAIL esr src=%0d: got %h required %h", s, rd2, m_spr[62]);
            else n_pass++;
            breq[s] = 1'b0;
            @(negedge clk);
            n_total++;
            if ({ack, back} !== 9'h0) $display("FAIL ack_pulse src=%0d: got %b required 0", s, {ack, back});
            else n_pass++;
        end
    endtask

    task automatic expect_no_ack(input string name);
        logic seen;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ack !== 1'b0 || back !== 8'h0) seen = 1'b1;
        end
        n_total++;
        if (seen) $display("FAIL %s: ack seen, required none", name);
        else n_pass++;
    endtask

    task automatic test_reset();
        int mlist [19];
        rst = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        n_total++;
        if ({ack, back} !== 9'h0) $display("FAIL reset_acks: got %b required 0", {ack, back});
        else n_pass++;
        n_total++;
        if (excepCode !== 4'd0 || intrEntryAddr !== 32'h0)
            $display("FAIL reset_outs: got code=%0d addr=%h required 0/0", excepCode, intrEntryAddr);
        else n_pass++;
        mlist[0] = 27; mlist[1] = 62; mlist[2] = 63;
        for (int i = 0; i < 16; i++) mlist[3 + i] = 400 + i;
        for (int i = 0; i < 19; i++) begin
            addr0 = 10'(mlist[i]); #1;
            n_total++;
            if (rd0 !== 32'h0) $display("FAIL reset_spr a=%0d: got %h required 0", mlist[i], rd0);
            else n_pass++;
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multiport_write();
        write3(402, 32'h20, 403, 32'h30, 413, 32'hD0);
        @(negedge clk);
        addr0 = 10'd402; addr1 = 10'd403; addr2 = 10'd413; #1;
        n_total++;
        if ({rd0, rd1, rd2} !== {32'h20, 32'h30, 32'hD0})
            $display("FAIL multiport_rd: got %h %h %h required 20 30 d0", rd0, rd1, rd2);
        else n_pass++;
    endtask

    task automatic test_same_addr();
        write3(63, 32'h11111111, 63, 32'h22222222, 63, 32'h33333333);
        m_spr[63] = 32'h33333333;
        @(negedge clk);
        addr1 = 10'd63; #1;
        n_total++;
        if (rd1 !== 32'h33333333) $display("FAIL same_addr: got %h required 33333333", rd1);
        else n_pass++;
    endtask

    task automatic test_random_rw();
        int a [3];
        logic [31:0] d [3];
        logic [2:0] w;
        for (int it = 0; it < 40; it++) begin
            @(negedge clk);
            for (int p = 0; p < 3; p++) begin
                case ($urandom_range(0, 3))
                    0: a[p] = $urandom_range(0, 1023);
                    1: a[p] = 27 + 35 * $urandom_range(0, 1) + $urandom_range(0, 1);
                    default: a[p] = 400 + $urandom_range(0, 15);
                endcase
                d[p] = $urandom;
                w[p] = 1'($urandom_range(0, 1));
            end
            addr0 = 10'(a[0]); wd0 = d[0]; wr0 = w[0];
            addr1 = 10'(a[1]); wd1 = d[1]; wr1 = w[1];
            addr2 = 10'(a[2]); wd2 = d[2]; wr2 = w[2];
            #1;
            n_total++;
            if ({rd0, rd1, rd2} !== {m_read(a[0]), m_read(a[1]), m_read(a[2])})
                $display("FAIL rand_rd it=%0d: got %h %h %h required %h %h %h", it, rd0, rd1, rd2,
                         m_read(a[0]), m_read(a[1]), m_read(a[2]));
            else n_pass++;
            @(posedge clk); #1;
            for (int p = 0; p < 3; p++) if (w[p] && mapped(a[p])) m_spr[a[p]] = d[p];
        end
        wr0 = 1'b0; wr1 = 1'b0; wr2 = 1'b0;
    endtask

    task automatic test_dev0();
        write3(63, 32'hFFFF0000, 404, 32'h40, 405, 32'h50);
        @(negedge clk);
        MSR = 32'h0000C000;
        breq[S_DEV0] = 1'b1;
        n_total++;
        if (exp_vec(S_DEV0) !== 32'hFFFF0040) $display("FAIL dev0_model: got %h required ffff0040", exp_vec(S_DEV0));
        else n_pass++;
        expect_grant(S_DEV0);
    endtask

    task automatic test_dev1_mask();
        MSR = 32'h0;
        breq[S_DEV1] = 1'b1;
        expect_no_ack("dev1_masked");
        MSR = 32'h0000C000;
        expect_grant(S_DEV1);
    endtask

    task automatic test_prog_vs_dev0();
        progErrCode = 3'b100;
        breq[S_PROG] = 1'b1;
        breq[S_DEV0] = 1'b1;
        expect_grant(S_PROG);
        n_total++;
        if (m_spr[62][27:25] !== 3'b100) $display("FAIL esr_field: got %b required 100", m_spr[62][27:25]);
        else n_pass++;
        expect_grant(S_DEV0);
    endtask

    task automatic test_sc_itlb_dtlb();
        write3(408, 32'h80, 414, 32'hE0, 413, 32'hD0);
        breq[S_SC] = 1'b1;
        expect_grant(S_SC);
        breq[S_ITLB] = 1'b1;
        expect_grant(S_ITLB);
        breq[S_DTLB] = 1'b1;
        expect_grant(S_DTLB);
    endtask

    task automatic test_write_during_grant();
        logic [31:0] ev_old;
        ev_old = exp_vec(S_SC);
        MSR = 32'h1234C5A6;
        breq[S_SC] = 1'b1;
        addr0 = 10'd408; wd0 = 32'h00001230; wr0 = 1'b1;
        addr1 = 10'd27;  wd1 = 32'hDEADBEEF; wr1 = 1'b1;
        @(posedge clk); #1;
        wr0 = 1'b0; wr1 = 1'b0;
        m_spr[408] = 32'h00001230;
        m_spr[27] = MSR;
        n_total++;
        if (ack !== 1'b1 || SC_ack !== 1'b1) $display("FAIL wdg_ack: got %b%b required 11", ack, SC_ack);
        else n_pass++;
        n_total++;
        if (intrEntryAddr !== ev_old) $display("FAIL wdg_vec: got %h required %h", intrEntryAddr, ev_old);
        else n_pass++;
        n_total++;
        if (rd1 !== MSR) $display("FAIL wdg_srr1: got %h required %h", rd1, MSR);
        else n_pass++;
        breq[S_SC] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (rd0 !== 32'h00001230) $display("FAIL wdg_ivor8: got %h required 00001230", rd0);
        else n_pass++;
    endtask

    task automatic test_random_grants();
        int w;
        int guard;
        for (int r = 0; r < 12; r++) begin
            @(negedge clk);
            breq = 8'($urandom);
            progErrCode = 3'($urandom);
            MSR = $urandom;
            if ($urandom_range(0, 1) == 1) MSR[15] = 1'b1;
            w = exp_winner(breq, MSR[15]);
            guard = 0;
            while (w >= 0 && guard < 10) begin
                expect_grant(w);
                w = exp_winner(breq, MSR[15]);
                guard++;
            end
            if (breq != 8'h0) expect_no_ack("masked_only");
            breq = 8'h0;
        end
    endtask

    task automatic test_reset_mid_grant();
        logic seen;
        @(negedge clk);
        breq[S_DSI] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            if (ack === 1'b1) seen = 1'b1;
        end
        n_total++;
        if (!seen) $display("FAIL rst_mid_setup: ack=0 required 1");
        else n_pass++;
        #1 rst = 1'b0;
        #1;
        n_total++;
        if ({ack, back} !== 9'h0 || excepCode !== 4'd0)
            $display("FAIL rst_mid: got acks=%b code=%0d required 0/0", {ack, back}, excepCode);
        else n_pass++;
        breq = 8'h0;
        clear_model();
        addr0 = 10'd63; #1;
        n_total++;
        if (rd0 !== 32'h0) $display("FAIL rst_mid_spr: got %h required 0", rd0);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        breq[S_DSI] = 1'b1;
        expect_grant(S_DSI);
    endtask

    initial begin
        rst = 1'b0;
        addr0 = '0; addr1 = '0; addr2 = '0;
        wd0 = '0; wd1 = '0; wd2 = '0;
        wr0 = 1'b0; wr1 = 1'b0; wr2 = 1'b0;
        MSR = '0; breq = '0; progErrCode = '0;
        test_reset();
        test_multiport_write();
        test_same_addr();
        test_random_rw();
        test_dev0();
        test_dev1_mask();
        test_prog_vs_dev0();
        test_sc_itlb_dtlb();
        test_write_during_grant();
        test_random_grants();
        test_reset_mid_grant();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
